// File: rtl/vred_beat_seq_pkg.sv
// Shared vALU definitions: op-select and element-width codes, FSM state encoding,
// and the identity-value and elements-per-beat helpers used by the reduction sequencer.
// Pure declarations, no logic or timing.
package vred_beat_seq_pkg;

  // op select codes
  localparam logic [1:0] OP_RSVD = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // element width codes; the code is also log2(bytes per element)
  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCALAR,
    ST_FETCH,
    ST_WAIT
  } state_t;

  // Fill bit for identity elements: all ones for and, zero for everything else.
  function automatic logic identity_fill(input logic [1:0] op);
    logic r;
    case (op)
      OP_AND:                  r = 1'b1;
      OP_OR, OP_XOR, OP_RSVD:  r = 1'b0;
    endcase
    return r;
  endfunction

  // log2 of elements per 64-bit beat (EPB = 8 >> sew).
  function automatic logic [1:0] epb_log2(input logic [1:0] sew);
    logic [1:0] r;
    case (sew)
      SEW_8:  r = 2'd3;
      SEW_16: r = 2'd2;
      SEW_32: r = 2'd1;
      SEW_64: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vred_elem_mask.sv
// Purpose: per-element tail/mask qualification of one beat; inactive elements get the identity.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: data/mask = beat and its v0 bits, vm = unmasked, sew/vl = element width and length,
//        beat = beat index, fill = identity fill bit, vec = qualified beat.
module vred_elem_mask
  import vred_beat_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int VL_WIDTH   = 11
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [7:0]            mask,
  input  logic                  vm,
  input  logic [SEW_WIDTH-1:0]  sew,
  input  logic [VL_WIDTH-1:0]   vl,
  input  logic [VL_WIDTH-1:0]   beat,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] vec
);

  localparam int LANES = DATA_WIDTH / 8;
  // global element index can reach beat*8+7, so leave headroom above VL_WIDTH
  localparam int EW = VL_WIDTH + 4;

  logic [EW-1:0] base;
  logic [EW-1:0] gidx;
  logic [2:0]    elem;
  logic          act;

  // Work per byte lane: a lane belongs to element (lane >> sew), so one
  // decision per lane covers every element width.
  always_comb begin
    vec  = '0;
    gidx = '0;
    elem = '0;
    act  = 1'b0;
    base = EW'(beat) << epb_log2(2'(sew));
    for (int j = 0; j < LANES; j++) begin
      elem = 3'(j) >> sew;
      gidx = base + EW'(elem);
      act  = (gidx < EW'(vl)) && (vm || mask[elem]);
      vec[8*j +: 8] = act ? data[8*j +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/vred_beat_seq.sv
// Purpose: sequences a vector reduction into beats (scalar beat, then one beat per fetched register beat).
// Latency: each beat is registered one cycle after its cause (request accept / read response).
// Backpressure: req_ready only in IDLE; one read outstanding; beats are pushed without a ready.
// Ports: req_* = reduction request, rd_req_* / rd_resp_* = register-beat read channel,
//        out_* = registered beat stream with start/end markers and the op/SEW it belongs to.
module vred_beat_seq
  import vred_beat_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int OPSEL_WIDTH = 2,
  parameter int SEW_WIDTH   = 2,
  parameter int VL_WIDTH    = 11,
  parameter int IDX_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPSEL_WIDTH-1:0] req_opSel,
  input  logic [SEW_WIDTH-1:0]   req_sew,
  input  logic [VL_WIDTH-1:0]    req_vl,
  input  logic                   req_vm,
  input  logic [DATA_WIDTH-1:0]  req_scalar,
  output logic                   rd_req_valid,
  output logic [IDX_WIDTH-1:0]   rd_req_idx,
  input  logic                   rd_resp_valid,
  input  logic [DATA_WIDTH-1:0]  rd_resp_data,
  input  logic [7:0]             rd_resp_mask,
  output logic [DATA_WIDTH-1:0]  out_vec0,
  output logic                   out_valid,
  output logic                   out_start,
  output logic                   out_end,
  output logic [OPSEL_WIDTH-1:0] out_opSel,
  output logic [SEW_WIDTH-1:0]   out_sew
);

  state_t state_q, state_d;

  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic [SEW_WIDTH-1:0]   sew_q;
  logic [VL_WIDTH-1:0]    vl_q;
  logic                   vm_q;
  logic [DATA_WIDTH-1:0]  scalar_q;
  logic [VL_WIDTH-1:0]    nb_q;
  logic [VL_WIDTH-1:0]    cnt_q, cnt_d;

  logic [1:0]             req_log;
  logic [VL_WIDTH:0]      vl_round;
  logic [VL_WIDTH-1:0]    nb_calc;
  logic                   last_beat;
  logic                   fill;

  logic                   accept;
  logic                   beat_vld;
  logic                   beat_start;
  logic                   beat_end;

  logic [DATA_WIDTH-1:0]  m_data;
  logic [7:0]             m_mask;
  logic                   m_vm;
  logic [VL_WIDTH-1:0]    m_vl;
  logic [VL_WIDTH-1:0]    m_beat;
  logic [DATA_WIDTH-1:0]  m_vec;

  assign req_ready = (state_q == ST_IDLE);
  assign fill      = identity_fill(2'(opsel_q));
  assign last_beat = (cnt_q == nb_q - VL_WIDTH'(1));

  // Beat count ceil(vl / EPB), one bit wider so vl+EPB-1 cannot wrap.
  always_comb begin
    req_log  = epb_log2(2'(req_sew));
    vl_round = {1'b0, req_vl} + ((VL_WIDTH+1)'(1) << req_log) - (VL_WIDTH+1)'(1);
    nb_calc  = VL_WIDTH'(vl_round >> req_log);
  end

  // The scalar beat reuses the masking path: an unmasked one-element vector
  // whose only element is the scalar leaves element 0 and fills the rest.
  vred_elem_mask #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEW_WIDTH  (SEW_WIDTH),
    .VL_WIDTH   (VL_WIDTH)
  ) u_elem_mask (
    .data (m_data),
    .mask (m_mask),
    .vm   (m_vm),
    .sew  (sew_q),
    .vl   (m_vl),
    .beat (m_beat),
    .fill (fill),
    .vec  (m_vec)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    beat_vld     = 1'b0;
    beat_start   = 1'b0;
    beat_end     = 1'b0;
    rd_req_valid = 1'b0;
    rd_req_idx   = IDX_WIDTH'(cnt_q);
    m_data       = rd_resp_data;
    m_mask       = rd_resp_mask;
    m_vm         = vm_q;
    m_vl         = vl_q;
    m_beat       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SCALAR;
        end
      end
      ST_SCALAR: begin
        m_data     = scalar_q;
        m_mask     = 8'hFF;
        m_vm       = 1'b1;
        m_vl       = VL_WIDTH'(1);
        m_beat     = '0;
        beat_vld   = 1'b1;
        beat_start = 1'b1;
        beat_end   = (nb_q == '0);
        state_d    = (nb_q == '0) ? ST_IDLE : ST_FETCH;
      end
      ST_FETCH: begin
        rd_req_valid = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_resp_valid) begin
          beat_vld = 1'b1;
          if (last_beat) begin
            beat_end = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            // overlap the next read with this response to save a cycle per beat
            cnt_d        = cnt_q + VL_WIDTH'(1);
            rd_req_valid = 1'b1;
            rd_req_idx   = IDX_WIDTH'(cnt_q + VL_WIDTH'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a read issued in the reset cycle would never be answered into a live reduction
    if (rst) begin
      rd_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      nb_q      <= '0;
      opsel_q   <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      scalar_q  <= '0;
      out_vec0  <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
      out_opSel <= '0;
      out_sew   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        opsel_q  <= req_opSel;
        sew_q    <= req_sew;
        vl_q     <= req_vl;
        vm_q     <= req_vm;
        scalar_q <= req_scalar;
        nb_q     <= nb_calc;
      end
      out_valid <= beat_vld;
      out_vec0  <= beat_vld ? m_vec : '0;
      out_start <= beat_vld & beat_start;
      out_end   <= beat_vld & beat_end;
      if (beat_vld) begin
        out_opSel <= opsel_q;
        out_sew   <= sew_q;
      end
    end
  end

endmodule
